// File: rtl/data_write_fifo.sv
// -----------------------------------------------------------------------------
// data_write_fifo
//
// Store buffer between commit and the data-memory write port. Committed stores
// are queued in order and presented one at a time to memory as a word-aligned
// write with byte-lane strobes. Loads from execute can snoop the buffer to see
// whether any pending store touches the same 32-bit word. The first write fault
// is held in a sticky flag together with the faulting store's byte address.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-low reset
//   datafifo_addr_in    store byte address from commit
//   datafifo_val_in     store value, right-justified
//   datafifo_size_in    0=byte, 1=half, 2/3=word
//   datafifo_valid_in   push request
//   datafifo_full       no free entry
//   mem_wr_addr         head address, word aligned
//   mem_wr_data         head value shifted into its byte lanes
//   mem_wr_strb         head byte-lane enables
//   mem_wr_valid        head entry present
//   mem_wr_ready        memory accepts the head entry
//   mem_wr_fault        access fault, meaningful only on an accept
//   snoop_addr          load address to compare against pending stores
//   snoop_hit           a pending store covers the same word
//   empty               no pending entries
//   fault_valid         sticky write-fault flag
//   fault_addr          byte address of the recorded faulting store
//   fault_clear         clears fault_valid
// -----------------------------------------------------------------------------
module data_write_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] datafifo_addr_in,
    input  logic [31:0] datafifo_val_in,
    input  logic [1:0]  datafifo_size_in,
    input  logic        datafifo_valid_in,
    output logic        datafifo_full,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_strb,
    output logic        mem_wr_valid,
    input  logic        mem_wr_ready,
    input  logic        mem_wr_fault,
    input  logic [31:0] snoop_addr,
    output logic        snoop_hit,
    output logic        empty,
    output logic        fault_valid,
    output logic [31:0] fault_addr,
    input  logic        fault_clear
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   addr_mem [DEPTH];
    logic [31:0]   val_mem  [DEPTH];
    logic [1:0]    size_mem [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic          fault_evt;

    logic [31:0]   head_addr;
    logic [31:0]   head_val;
    logic [1:0]    head_size;
    logic [1:0]    byte_off;
    logic [AW-1:0] slot;

    assign datafifo_full = (count == FULL_COUNT);
    assign empty         = (count == '0);
    assign mem_wr_valid  = !empty;

    // A push while full is dropped even if the head pops in the same cycle.
    assign push      = datafifo_valid_in && !datafifo_full;
    assign pop       = mem_wr_valid && mem_wr_ready;
    assign fault_evt = pop && mem_wr_fault;

    // NOTE: the entry storage has no reset; validity comes from count and the
    //       pointers, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            addr_mem[wr_ptr] <= datafifo_addr_in;
            val_mem[wr_ptr]  <= datafifo_val_in;
            size_mem[wr_ptr] <= datafifo_size_in;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    //       samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fault_valid <= 1'b0;
            fault_addr  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase

            // A new fault wins over fault_clear; a fault while the flag is
            // already held leaves the first address in place.
            if (fault_evt && (!fault_valid || fault_clear)) begin
                fault_valid <= 1'b1;
                fault_addr  <= head_addr;
            end else if (fault_clear) begin
                fault_valid <= 1'b0;
            end
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_val  = val_mem[rd_ptr];
    assign head_size = size_mem[rd_ptr];
    assign byte_off  = head_addr[1:0];

    assign mem_wr_addr = {head_addr[31:2], 2'b00};
    assign mem_wr_data = head_val << {byte_off, 3'b000};

    // NOTE: every always_comb output gets a default first so no path can
    //       leave it unassigned and infer a latch.
    always_comb begin
        mem_wr_strb = 4'b1111;
        case (head_size)
            2'd0:    mem_wr_strb = 4'b0001 << byte_off;
            2'd1:    mem_wr_strb = 4'b0011 << byte_off;
            default: mem_wr_strb = 4'b1111;
        endcase
    end

    // Only the count entries starting at rd_ptr are live; a store being
    // pushed this cycle is not yet in the array and so cannot hit.
    always_comb begin
        snoop_hit = 1'b0;
        slot      = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + AW'(i);
            if ((CW'(i) < count) && (addr_mem[slot][31:2] == snoop_addr[31:2])) begin
                snoop_hit = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_write_fifo.sv
// -----------------------------------------------------------------------------
// tb_data_write_fifo
//
// Directed stimulus for data_write_fifo. A queue-based reference model tracks
// the pending stores and the fault record; a negedge compare process checks
// every DUT output against it each cycle, and the stimulus adds literal
// expectations for the scenarios of interest.
// -----------------------------------------------------------------------------
module tb_data_write_fifo;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] datafifo_addr_in;
    logic [31:0] datafifo_val_in;
    logic [1:0]  datafifo_size_in;
    logic        datafifo_valid_in;
    logic        datafifo_full;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_strb;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic        mem_wr_fault;
    logic [31:0] snoop_addr;
    logic        snoop_hit;
    logic        empty;
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic        fault_clear;

    data_write_fifo #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .datafifo_addr_in  (datafifo_addr_in),
        .datafifo_val_in   (datafifo_val_in),
        .datafifo_size_in  (datafifo_size_in),
        .datafifo_valid_in (datafifo_valid_in),
        .datafifo_full     (datafifo_full),
        .mem_wr_addr       (mem_wr_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_wr_strb       (mem_wr_strb),
        .mem_wr_valid      (mem_wr_valid),
        .mem_wr_ready      (mem_wr_ready),
        .mem_wr_fault      (mem_wr_fault),
        .snoop_addr        (snoop_addr),
        .snoop_hit         (snoop_hit),
        .empty             (empty),
        .fault_valid       (fault_valid),
        .fault_addr        (fault_addr),
        .fault_clear       (fault_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] val;
        logic [1:0]  size;
    } entry_t;

    entry_t      q[$];
    logic        m_fv;
    logic [31:0] m_fa;
    bit          model_on = 0;

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        bit do_pop;
        bit do_push;
        if (!reset) begin
            q.delete();
            m_fv = 1'b0;
            m_fa = '0;
        end else begin
            do_pop  = (q.size() != 0) && mem_wr_ready;
            do_push = datafifo_valid_in && (q.size() < DEPTH);
            if (do_pop && mem_wr_fault && (!m_fv || fault_clear)) begin
                m_fv = 1'b1;
                m_fa = q[0].addr;
            end else if (fault_clear) begin
                m_fv = 1'b0;
            end
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{datafifo_addr_in, datafifo_val_in, datafifo_size_in});
        end
    endtask

    function automatic logic [3:0] model_strb(entry_t e);
        int nbytes;
        int off;
        logic [3:0] s;
        nbytes = (e.size == 2'd0) ? 1 : (e.size == 2'd1) ? 2 : 4;
        off    = int'(e.addr[1:0]);
        s      = 4'b0000;
        if (nbytes == 4) begin
            s = 4'b1111;
        end else begin
            for (int k = 0; k < nbytes; k++) begin
                if (off + k < 4) s[off + k] = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic logic model_hit(logic [31:0] a);
        logic h;
        h = 1'b0;
        foreach (q[i]) begin
            if ((q[i].addr >> 2) == (a >> 2)) h = 1'b1;
        end
        return h;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_on) begin
            logic [31:0] exp_data;
            check("cyc full",  32'(datafifo_full), 32'(q.size() == DEPTH));
            check("cyc empty", 32'(empty),         32'(q.size() == 0));
            check("cyc valid", 32'(mem_wr_valid),  32'(q.size() != 0));
            check("cyc snoop", 32'(snoop_hit),     32'(model_hit(snoop_addr)));
            check("cyc fault_valid", 32'(fault_valid), 32'(m_fv));
            check("cyc fault_addr",  fault_addr,       m_fa);
            if (q.size() != 0) begin
                exp_data = q[0].val << (8 * int'(q[0].addr[1:0]));
                check("cyc wr_addr", mem_wr_addr, q[0].addr & 32'hFFFF_FFFC);
                check("cyc wr_data", mem_wr_data, exp_data);
                check("cyc wr_strb", 32'(mem_wr_strb), 32'(model_strb(q[0])));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
        datafifo_addr_in  = a;
        datafifo_val_in   = v;
        datafifo_size_in  = s;
        datafifo_valid_in = 1'b1;
        tick();
        datafifo_valid_in = 1'b0;
    endtask

    // Drain with ready=1 and compare each accepted head address with exp_list.
    task automatic drain(input string name, input logic [31:0] exp_list[$]);
        int n;
        n = 0;
        mem_wr_ready = 1'b1;
        for (int c = 0; c < 2 * DEPTH + 2; c++) begin
            if (mem_wr_valid) begin
                if (n < exp_list.size()) check({name, " order"}, mem_wr_addr, exp_list[n]);
                n++;
            end
            tick();
        end
        check({name, " count"}, 32'(n), 32'(exp_list.size()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset             = 1'b0;
        datafifo_addr_in  = '0;
        datafifo_val_in   = '0;
        datafifo_size_in  = '0;
        datafifo_valid_in = 1'b0;
        mem_wr_ready      = 1'b0;
        mem_wr_fault      = 1'b0;
        snoop_addr        = '0;
        fault_clear       = 1'b0;
        m_fv              = 1'b0;
        m_fa              = '0;

        tick();
        tick();
        model_on = 1;
        check("reset empty", 32'(empty), 32'd1);
        check("reset full",  32'(datafifo_full), 32'd0);
        check("reset valid", 32'(mem_wr_valid), 32'd0);
        check("reset fault", 32'(fault_valid), 32'd0);
        reset = 1'b1;
        tick();

        // Misaligned byte store lands in lane 3, popped the next cycle.
        mem_wr_ready = 1'b1;
        push_one(32'h0000_1003, 32'h0000_00AB, 2'd0);
        check("byte addr",  mem_wr_addr, 32'h0000_1000);
        check("byte data",  mem_wr_data, 32'hAB00_0000);
        check("byte strb",  32'(mem_wr_strb), 32'h8);
        check("byte valid", 32'(mem_wr_valid), 32'd1);
        tick();
        check("byte popped", 32'(empty), 32'd1);

        // Fill, overflow attempt, then drain in order.
        mem_wr_ready = 1'b0;
        push_one(32'h0000_0100, 32'h1111_1111, 2'd2);
        push_one(32'h0000_0104, 32'h2222_2222, 2'd2);
        push_one(32'h0000_0108, 32'h3333_3333, 2'd2);
        check("not full at 3", 32'(datafifo_full), 32'd0);
        push_one(32'h0000_010C, 32'h4444_4444, 2'd3);
        check("full at 4", 32'(datafifo_full), 32'd1);
        push_one(32'h0000_0110, 32'h5555_5555, 2'd2);
        check("full after 5th", 32'(datafifo_full), 32'd1);
        check("head still 1st", mem_wr_addr, 32'h0000_0100);
        drain("fill", '{32'h100, 32'h104, 32'h108, 32'h10C});
        check("fill drained", 32'(empty), 32'd1);

        // Push against a full buffer while popping: push rejected.
        mem_wr_ready = 1'b0;
        push_one(32'h0000_0200, 32'hA0, 2'd2);
        push_one(32'h0000_0204, 32'hA1, 2'd2);
        push_one(32'h0000_0208, 32'hA2, 2'd2);
        push_one(32'h0000_020C, 32'hA3, 2'd2);
        mem_wr_ready = 1'b1;
        push_one(32'h0000_0210, 32'hA4, 2'd2);
        check("full push+pop not full", 32'(datafifo_full), 32'd0);
        check("full push+pop head", mem_wr_addr, 32'h0000_0204);
        // Not full: push+pop keeps three entries and wraps both pointers.
        push_one(32'h0000_0214, 32'hA5, 2'd2);
        check("pp1 head", mem_wr_addr, 32'h0000_0208);
        push_one(32'h0000_0218, 32'hA6, 2'd2);
        push_one(32'h0000_021C, 32'hA7, 2'd2);
        check("pp3 head", mem_wr_addr, 32'h0000_0214);
        check("pp3 data", mem_wr_data, 32'h0000_00A5);
        drain("wrap", '{32'h214, 32'h218, 32'h21C});

        // Snoop against a pending half store.
        mem_wr_ready = 1'b0;
        push_one(32'h0000_2002, 32'h0000_BEEF, 2'd1);
        check("half strb", 32'(mem_wr_strb), 32'hC);
        check("half data", mem_wr_data, 32'hBEEF_0000);
        snoop_addr = 32'h0000_2000;
        #1;
        check("snoop same word", 32'(snoop_hit), 32'd1);
        snoop_addr = 32'h0000_2004;
        #1;
        check("snoop next word", 32'(snoop_hit), 32'd0);
        snoop_addr = 32'h0000_2000;
        mem_wr_ready = 1'b1;
        tick();
        check("snoop after drain", 32'(snoop_hit), 32'd0);
        // An entry being pushed this cycle does not hit yet.
        snoop_addr        = 32'h0000_3000;
        datafifo_addr_in  = 32'h0000_3000;
        datafifo_size_in  = 2'd2;
        datafifo_val_in   = 32'h77;
        datafifo_valid_in = 1'b1;
        #1;
        check("snoop same-cycle push", 32'(snoop_hit), 32'd0);
        tick();
        datafifo_valid_in = 1'b0;
        tick();

        // Fault capture, hold, and clear-vs-new-fault priority.
        mem_wr_ready = 1'b0;
        push_one(32'h0000_3001, 32'h0000_005A, 2'd0);
        push_one(32'h0000_4000, 32'h1234_5678, 2'd2);
        push_one(32'h0000_5000, 32'h9ABC_DEF0, 2'd2);
        check("3001 strb", 32'(mem_wr_strb), 32'h2);
        check("3001 data", mem_wr_data, 32'h0000_5A00);
        mem_wr_ready = 1'b1;
        mem_wr_fault = 1'b1;
        tick();
        check("fault 1 valid", 32'(fault_valid), 32'd1);
        check("fault 1 addr",  fault_addr, 32'h0000_3001);
        tick();
        check("fault 2 held",  fault_addr, 32'h0000_3001);
        fault_clear = 1'b1;
        tick();
        check("fault 3 valid", 32'(fault_valid), 32'd1);
        check("fault 3 addr",  fault_addr, 32'h0000_5000);
        mem_wr_fault = 1'b0;
        tick();
        check("fault cleared", 32'(fault_valid), 32'd0);
        fault_clear = 1'b0;

        // Reset with entries pending, ready high and a push requested.
        push_one(32'h0000_6000, 32'h1, 2'd2);
        mem_wr_fault = 1'b1;
        tick();
        mem_wr_fault = 1'b0;
        mem_wr_ready = 1'b0;
        push_one(32'h0000_7000, 32'h2, 2'd2);
        push_one(32'h0000_7004, 32'h3, 2'd2);
        push_one(32'h0000_7008, 32'h4, 2'd2);
        check("pre-reset fault", 32'(fault_valid), 32'd1);
        snoop_addr        = 32'h0000_7004;
        reset             = 1'b0;
        mem_wr_ready      = 1'b1;
        datafifo_addr_in  = 32'h0000_8000;
        datafifo_valid_in = 1'b1;
        tick();
        reset             = 1'b1;
        datafifo_valid_in = 1'b0;
        #1;
        check("mid reset empty", 32'(empty), 32'd1);
        check("mid reset valid", 32'(mem_wr_valid), 32'd0);
        check("mid reset fault", 32'(fault_valid), 32'd0);
        check("mid reset faddr", fault_addr, 32'h0);
        check("mid reset snoop", 32'(snoop_hit), 32'd0);
        tick();
        push_one(32'h0000_9002, 32'h0000_00CD, 2'd0);
        check("post reset addr", mem_wr_addr, 32'h0000_9000);
        check("post reset data", mem_wr_data, 32'h00CD_0000);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
